system_fetch_8: RTL and testbench



---
 rtl/system_fetch_8.sv | 183 ++++++++++++++++++
 tb/tb_system_fetch_8.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/system_fetch_8.sv
// system_fetch_8: instruction-fetch stage for the 8-bit processor.
// Holds the fetch PC and drives a synchronous-read instruction memory.
// Returned words go to decode through an output register and a one-entry skid
// buffer. A redirect from the PC-update stage reloads the PC and flushes
// wrong-path words.
//
// Ports:
//   system1000 / system1000_rstn  clock, synchronous active-low reset
//   redirect_i, redirect_pc_i     PC reload (taken jump/branch), highest priority
//   halt_i                        stop issuing new fetches (FSM -> HALTED)
//   imem_en_o, imem_addr_o        memory issue strobe and address (fetch PC)
//   imem_rdata_i                  memory data, valid one cycle after imem_en_o
//   instr_valid_o, instr_o,
//   instr_pc_o, dec_ready_i       valid/ready handshake toward decode
//   halted_o                      FSM is in HALTED
// Optional: define FETCH_PERF_EN to add the saturating fetch_cnt_o and
// stall_cnt_o performance counters.
module system_fetch_8 #(
  parameter int unsigned       INSTR_W  = 16,
  parameter logic signed [7:0] RESET_PC = 8'sd0
) (
  input  logic                    system1000,
  input  logic                    system1000_rstn,
  input  logic                    redirect_i,
  input  logic signed [7:0]       redirect_pc_i,
  input  logic                    halt_i,
  output logic                    imem_en_o,
  output logic [7:0]              imem_addr_o,
  input  logic [INSTR_W-1:0]      imem_rdata_i,
  output logic                    instr_valid_o,
  output logic [INSTR_W-1:0]      instr_o,
  output logic signed [7:0]       instr_pc_o,
  input  logic                    dec_ready_i,
  output logic                    halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]             fetch_cnt_o,
  output logic [15:0]             stall_cnt_o
`endif
);

  localparam int unsigned PC_W = 8;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic signed [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic                      inflight_q, inflight_d;
  logic signed [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic                      skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0]        skid_instr_q, skid_instr_d;
  logic signed [PC_W-1:0]    skid_pc_q, skid_pc_d;
  logic                      out_valid_q, out_valid_d;
  logic [INSTR_W-1:0]        out_instr_q, out_instr_d;
  logic signed [PC_W-1:0]    out_pc_q, out_pc_d;

  logic issue;
  logic handshake;
  logic ret_taken;

  // Next-state, issue decision and return routing.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    ret_taken     = 1'b0;

    handshake = out_valid_q & dec_ready_i;
    // Holding off while a return would land behind a stalled output keeps the
    // buffer at one in flight + output + skid.
    issue = system1000_rstn & (state_q == RUN) & ~halt_i & ~redirect_i
          & ~skid_valid_q & ~(inflight_q & out_valid_q & ~dec_ready_i);

    if (state_q == RUN) begin
      if (halt_i) state_d = HALTED;
    end else begin
      if (redirect_i && !halt_i) state_d = RUN;
    end

    if (redirect_i) begin
      fetch_pc_d   = redirect_pc_i;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 8'sd1;
      end
      if (handshake) out_valid_d = 1'b0;
      // Output refills from skid first, then from the returning word.
      if (!out_valid_q || handshake) begin
        if (skid_valid_q) begin
          out_valid_d  = 1'b1;
          out_instr_d  = skid_instr_q;
          out_pc_d     = skid_pc_q;
          skid_valid_d = 1'b0;
        end else if (inflight_q) begin
          out_valid_d = 1'b1;
          out_instr_d = imem_rdata_i;
          out_pc_d    = inflight_pc_q;
          ret_taken   = 1'b1;
        end
      end
      if (inflight_q && !ret_taken) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata_i;
        skid_pc_d    = inflight_pc_q;
      end
    end
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= '0;
      out_pc_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
    end
  end

  assign imem_en_o     = issue;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = out_valid_q;
  assign instr_o       = out_instr_q;
  assign instr_pc_o    = out_pc_q;
  assign halted_o      = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturating issue and decode-stall counters.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (issue && (fetch_cnt_q != 16'hFFFF)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (out_valid_q && !dec_ready_i && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge system1000) begin
    if (!system1000_rstn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_system_fetch_8.sv
// Testbench for system_fetch_8: directed scenarios followed by random
// ready/halt/redirect/reset traffic, checked against a program-order model.
module tb_system_fetch_8;

  localparam int unsigned       INSTR_W  = 16;
  localparam logic signed [7:0] RESET_PC = 8'sd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rstn = 1'b0;
  logic                    redirect = 1'b0;
  logic signed [7:0]       redirect_pc = 8'sd0;
  logic                    halt = 1'b0;
  logic                    dec_ready = 1'b0;
  logic                    imem_en;
  logic [7:0]              imem_addr;
  logic [INSTR_W-1:0]      imem_rdata;
  logic                    instr_valid;
  logic [INSTR_W-1:0]      instr;
  logic signed [7:0]       instr_pc;
  logic                    halted;
`ifdef FETCH_PERF_EN
  logic [15:0]             fetch_cnt;
  logic [15:0]             stall_cnt;
`endif

  system_fetch_8 #(.INSTR_W(INSTR_W), .RESET_PC(RESET_PC)) dut (
    .system1000      (clk),
    .system1000_rstn (rstn),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .halt_i          (halt),
    .imem_en_o       (imem_en),
    .imem_addr_o     (imem_addr),
    .imem_rdata_i    (imem_rdata),
    .instr_valid_o   (instr_valid),
    .instr_o         (instr),
    .instr_pc_o      (instr_pc),
    .dec_ready_i     (dec_ready),
    .halted_o        (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o     (fetch_cnt),
    .stall_cnt_o     (stall_cnt)
`endif
  );

  // Synchronous-read instruction memory.
  logic [INSTR_W-1:0] mem [256];
  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  int ncmp = 0;
  int nfail = 0;

  // Reference model: next PC to be fetched, next PC decode must see, FSM mode.
  logic [7:0] m_fetch = 8'h00;
  logic [7:0] m_exp   = 8'h00;
  bit         m_halted = 1'b0;

  bit                 prev_hold = 1'b0;
  bit                 prev_rst  = 1'b0;
  logic [INSTR_W-1:0] prev_instr = '0;
  logic signed [7:0]  prev_pc = 8'sd0;

  logic               s_en, s_valid, s_halted;
  logic [7:0]         s_addr;
  logic [7:0]         s_pc;
  logic [INSTR_W-1:0] s_instr;

  logic [7:0] wrap_exp [4] = '{8'h7E, 8'h7F, 8'h80, 8'h81};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check before the next posedge, update model.
  task automatic cycle(input bit rst_n_v, input bit rdy, input bit hlt,
                       input bit rd, input logic [7:0] rpc);
    bit hs;
    bit en;
    @(negedge clk);
    rstn = rst_n_v; dec_ready = rdy; halt = hlt; redirect = rd;
    redirect_pc = rpc;
    #1;
    s_en = imem_en; s_valid = instr_valid; s_halted = halted;
    s_addr = imem_addr; s_pc = $unsigned(instr_pc); s_instr = instr;
    if (prev_rst) begin
      chk("rst_valid",  32'(instr_valid), 0);
      chk("rst_instr",  32'(instr), 0);
      chk("rst_pc",     32'(s_pc), 0);
      chk("rst_halted", 32'(halted), 0);
`ifdef FETCH_PERF_EN
      chk("rst_fetch_cnt", 32'(fetch_cnt), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
`endif
    end
    if (!rst_n_v) begin
      chk("en_in_reset", 32'(imem_en), 0);
    end else begin
      chk("halted", 32'(halted), 32'(m_halted));
      chk("fetch_pc", 32'(imem_addr), 32'(m_fetch));
      if (m_halted || hlt || rd) chk("no_issue", 32'(imem_en), 0);
      if (prev_hold) begin
        chk("hold_valid", 32'(instr_valid), 1);
        chk("hold_instr", 32'(instr), 32'(prev_instr));
        chk("hold_pc",    32'(s_pc), 32'($unsigned(prev_pc)));
      end
      if (instr_valid && rdy) begin
        chk("stream_pc",    32'(s_pc), 32'(m_exp));
        chk("stream_instr", 32'(instr), 32'(mem[m_exp]));
      end
    end
    hs = rst_n_v && instr_valid && rdy;
    en = rst_n_v && imem_en;
    prev_hold  = rst_n_v && instr_valid && !rdy && !rd;
    prev_instr = instr;
    prev_pc    = instr_pc;
    prev_rst   = !rst_n_v;
    @(posedge clk);
    if (!rst_n_v) begin
      m_fetch = RESET_PC; m_exp = RESET_PC; m_halted = 1'b0;
    end else begin
      if (hs) m_exp = m_exp + 8'd1;
      if (rd) begin
        m_fetch = rpc; m_exp = rpc;
      end else if (en) begin
        m_fetch = m_fetch + 8'd1;
      end
      if (hlt) m_halted = 1'b1;
      else if (rd) m_halted = 1'b0;
    end
  endtask

  initial begin
    bit seen;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);

    // Reset and release with decode always ready.
    cycle(0, 1, 0, 0, 8'h00);
    cycle(0, 1, 0, 0, 8'h00);
    cycle(1, 1, 0, 0, 8'h00);
    chk("first_issue_en", 32'(s_en), 1);
    chk("first_issue_addr", 32'(s_addr), 32'(RESET_PC));
    chk("first_valid_low", 32'(s_valid), 0);
    cycle(1, 1, 0, 0, 8'h00);
    chk("second_valid_low", 32'(s_valid), 0);
    cycle(1, 1, 0, 0, 8'h00);
    chk("valid_rise", 32'(s_valid), 1);
    chk("first_instr", 32'(s_instr), 32'h1000);
    cycle(1, 1, 0, 0, 8'h00);
    chk("no_bubble_pc1", 32'(s_pc), 1);

    // Stall decode while PC 2 is presented.
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0, 8'h00);
      chk("stall_pc2", 32'(s_pc), 2);
      chk("stall_no_issue", 32'(s_en), 0);
    end

    // Run until PC 6 has just issued, then redirect to -5.
    n = 0;
    while (m_fetch != 8'd7 && n < 30) begin
      cycle(1, 1, 0, 0, 8'h00);
      n++;
    end
    chk("reach_pc6", 32'(m_fetch), 7);
    cycle(1, 1, 0, 1, 8'hFB);
    chk("redirect_no_issue", 32'(s_en), 0);
    cycle(1, 1, 0, 0, 8'h00);
    chk("redirect_issue_en", 32'(s_en), 1);
    chk("redirect_issue_addr", 32'(s_addr), 32'h00FB);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 0, 0, 8'h00);
      if (s_valid && s_pc == 8'hFB) seen = 1'b1;
      if (s_valid && s_pc == 8'h06) seen = 1'b0;
    end
    chk("redirect_target_seen", 32'(seen), 1);

    // Signed wrap of the fetch PC.
    cycle(1, 1, 0, 1, 8'h7E);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0, 8'h00);
      chk("wrap_en", 32'(s_en), 1);
      chk("wrap_addr", 32'(s_addr), 32'(wrap_exp[i]));
    end

    // Halt right after PC 10 issues; in-flight words drain.
    cycle(1, 1, 0, 1, 8'h08);
    n = 0;
    while (m_fetch != 8'd11 && n < 30) begin
      cycle(1, 1, 0, 0, 8'h00);
      n++;
    end
    chk("reach_pc10", 32'(m_fetch), 11);
    cycle(1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 8'h00);
    chk("halt_state", 32'(s_halted), 1);
    chk("halt_drained_valid", 32'(s_valid), 0);
    chk("halt_drained_all", 32'(m_exp), 32'(m_fetch));

    // Resume at 20.
    cycle(1, 1, 0, 1, 8'd20);
    cycle(1, 1, 0, 0, 8'h00);
    chk("resume_en", 32'(s_en), 1);
    chk("resume_addr", 32'(s_addr), 20);
    cycle(1, 1, 0, 0, 8'h00);

    // Halt together with redirect: PC loads, FSM halts.
    cycle(1, 1, 1, 1, 8'h28);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 0, 0, 8'h00);
      chk("halt_redir_state", 32'(s_halted), 1);
      chk("halt_redir_addr", 32'(s_addr), 32'h28);
      chk("halt_redir_no_issue", 32'(s_en), 0);
    end

    // Resume, fill output and skid, then reset mid-stall.
    cycle(1, 1, 0, 1, 8'h30);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 8'h00);
    chk("stall_before_reset", 32'(s_valid), 1);
    cycle(0, 0, 0, 0, 8'h00);
    cycle(1, 1, 0, 0, 8'h00);
    chk("post_reset_valid", 32'(s_valid), 0);
    chk("post_reset_en", 32'(s_en), 1);
    chk("post_reset_addr", 32'(s_addr), 32'(RESET_PC));

    // Random traffic with random memory contents.
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    cycle(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit rdy, hlt, rd, rs;
      r   = int'($urandom_range(0, 199));
      rdy = ($urandom_range(0, 9) < 7);
      rs  = (r == 199);
      hlt = (r < 5);
      rd  = (r >= 3 && r < 10) || (m_halted && r < 30);
      cycle(!rs, rdy, hlt, rd, 8'($urandom));
    end

    // Final drain under halt.
    cycle(1, 1, 1, 0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 8'h00);
    chk("final_drained_valid", 32'(s_valid), 0);
    chk("final_drained_all", 32'(m_exp), 32'(m_fetch));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
